// File: rtl/cozy_ps2_rx_if.sv
// CPU-side port of the PS/2 receiver: head byte, status flags and pop strobe.
// valid/rd semantics: valid high means data holds the FIFO head; rd sampled high
// at a clock edge while valid is high pops that entry, rd while empty is ignored.
interface cozy_ps2_rx_if;
  logic       rd;
  logic [7:0] data;
  logic       valid;
  logic       overflow;
  logic       frame_err;

  modport master (output rd, input data, valid, overflow, frame_err);
  modport slave  (input rd, output data, valid, overflow, frame_err);
endinterface

// File: rtl/cozy_ps2_rx.sv
// PS/2 device-to-host frame receiver feeding a show-ahead byte FIFO.
// Optional odd-parity checking is enabled by defining COZY_PS2_PARITY_EN.
module cozy_ps2_rx #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2500
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  cozy_ps2_rx_if.slave cpu,
  output logic [1:0]   dbg_state
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Line synchronizers; clk_prev gives edge detection on the synced clock
  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  state_t             state;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               frame_err_q;
  logic               parity_ok;
  logic               push_req;

`ifdef COZY_PS2_PARITY_EN
  logic parity_q;
  assign parity_ok = ^{shreg, parity_q};
`else
  assign parity_ok = 1'b1;
`endif

  assign push_req = (state == ST_STOP) && fall && dat_s2 && parity_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      tmo_cnt     <= '0;
      frame_err_q <= 1'b0;
`ifdef COZY_PS2_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      if (state == ST_IDLE) begin
        tmo_cnt <= '0;
        if (fall && !dat_s2) begin
          state   <= ST_DATA;
          bit_cnt <= 3'd0;
        end
      end else if (fall) begin
        tmo_cnt <= '0;
        case (state)
          ST_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
`ifdef COZY_PS2_PARITY_EN
            parity_q <= dat_s2;
`endif
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!(dat_s2 && parity_ok)) frame_err_q <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (tmo_cnt == TMO_MAX) begin
        // Line went quiet mid-frame: abandon it
        state       <= ST_IDLE;
        tmo_cnt     <= '0;
        frame_err_q <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // Show-ahead FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, count;
  logic             overflow_q;
  logic             full, do_pop, do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == PTR_W'(FIFO_DEPTH));
  assign do_pop  = cpu.rd && (count != '0);
  // A full FIFO still accepts the byte when a pop frees the slot this edge
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (push_req && full && !do_pop) overflow_q <= 1'b1;
      else if (do_pop)                 overflow_q <= 1'b0;
    end
  end

  assign cpu.valid     = (count != '0);
  assign cpu.data      = cpu.valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign cpu.overflow  = overflow_q;
  assign cpu.frame_err = frame_err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_cozy_ps2_rx.sv
// Directed bench for cozy_ps2_rx: table of single frames plus hand-written
// sequences for timing, overflow, coincident push/pop, timeout and reset.
module tb_cozy_ps2_rx;

  localparam int TMO = 64;

  logic       clk;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [1:0] dbg_state;

  cozy_ps2_rx_if cpu_if ();

  cozy_ps2_rx #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .cpu       (cpu_if.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) if (cpu_if.frame_err) err_pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_data = bits[i];
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bits({stop, par, b, 1'b0}, 11);
  endtask

  task automatic stop_begin();
    @(negedge clk) ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
  endtask

  task automatic stop_end(input int remaining);
    repeat (remaining) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk) cpu_if.rd = 1'b1;
    @(negedge clk) cpu_if.rd = 1'b0;
  endtask

  typedef struct {
    logic [7:0] byte_v;
    logic       par;
    logic       stop;
    logic       exp_err;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int base;
    int elapsed;

`ifdef COZY_PS2_PARITY_EN
    vecs[0] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
`else
    vecs[0] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C};
`endif
    vecs[1] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C};
    vecs[2] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80};
    vecs[6] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[7] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0};

    reset_n   = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    cpu_if.rd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", cpu_if.valid, 0);
    check("rst_data", cpu_if.data, 0);
    check("rst_overflow", cpu_if.overflow, 0);
    check("rst_frame_err", cpu_if.frame_err, 0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // single-frame vectors
    for (int v = 0; v < 8; v++) begin
      base = err_pulses;
      send_frame(vecs[v].byte_v, vecs[v].par, vecs[v].stop);
      check($sformatf("vec%0d_err", v), err_pulses - base, {31'd0, vecs[v].exp_err});
      check($sformatf("vec%0d_valid", v), cpu_if.valid, vecs[v].exp_valid);
      check($sformatf("vec%0d_data", v), cpu_if.data, vecs[v].exp_data);
      if (vecs[v].exp_valid) begin
        pop();
        check($sformatf("vec%0d_pop_valid", v), cpu_if.valid, 0);
        check($sformatf("vec%0d_pop_data", v), cpu_if.data, 0);
      end
    end

    // byte visible exactly one cycle after the stop-bit fall
    send_bits({2'b00, 8'h1C, 1'b0}, 10);
    stop_begin();
    repeat (2) @(negedge clk);
    check("stop_fall_cycle_valid", cpu_if.valid, 0);
    @(negedge clk);
    check("stop_next_valid", cpu_if.valid, 1);
    check("stop_next_data", cpu_if.data, 8'h1C);
    stop_end(7);
    pop();

    // rd while empty must not move pointers
    pop();
    check("empty_rd_valid", cpu_if.valid, 0);
    send_frame(8'h33, 1'b1, 1'b1);
    check("after_empty_rd_data", cpu_if.data, 8'h33);
    pop();
    check("after_empty_rd_drain", cpu_if.valid, 0);

    // overflow on 5th frame without reads
    send_frame(8'h01, 1'b0, 1'b1); exp_q.push_back(8'h01);
    send_frame(8'h02, 1'b0, 1'b1); exp_q.push_back(8'h02);
    send_frame(8'h03, 1'b1, 1'b1); exp_q.push_back(8'h03);
    send_frame(8'h04, 1'b0, 1'b1); exp_q.push_back(8'h04);
    check("full_no_overflow", cpu_if.overflow, 0);
    send_frame(8'h05, 1'b1, 1'b1);
    check("overflow_set", cpu_if.overflow, 1);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("ovf_read%0d", i), cpu_if.data, e);
      pop();
      check($sformatf("ovf_flag%0d", i), cpu_if.overflow, 0);
    end
    check("ovf_drained", cpu_if.valid, 0);

    // full FIFO, 5th push coincides with rd
    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'h02, 1'b0, 1'b1);
    send_frame(8'h03, 1'b1, 1'b1);
    send_frame(8'h04, 1'b0, 1'b1);
    send_bits({2'b01, 8'h05, 1'b0}, 10);
    stop_begin();
    repeat (2) @(negedge clk);
    check("coinc_head", cpu_if.data, 8'h01);
    cpu_if.rd = 1'b1;
    @(negedge clk);
    cpu_if.rd = 1'b0;
    check("coinc_overflow", cpu_if.overflow, 0);
    stop_end(7);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(i + 2));
    while (exp_q.size() != 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("coinc_read_%0h", e), cpu_if.data, e);
      pop();
    end
    check("coinc_drained", cpu_if.valid, 0);
    check("coinc_overflow_end", cpu_if.overflow, 0);

    // partial frame abandoned by timeout
    base = err_pulses;
    send_bits({7'd0, 3'b101, 1'b0}, 4);
    check("tmo_mid_state", dbg_state, 1);
    elapsed = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (cpu_if.frame_err) begin
        elapsed = i;
        break;
      end
    end
    check("tmo_latency_window", (elapsed >= 48 && elapsed <= 56) ? 1 : 0, 1);
    @(negedge clk);
    check("tmo_pulse_width", err_pulses - base, 1);
    check("tmo_state_idle", dbg_state, 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    check("tmo_next_data", cpu_if.data, 8'h5A);
    pop();

    // reset mid-frame with two bytes queued
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    check("pre_rst_valid", cpu_if.valid, 1);
    send_bits({6'd0, 4'b0110, 1'b0}, 5);
    @(negedge clk) reset_n = 1'b0;
    #1;
    check("midrst_valid", cpu_if.valid, 0);
    check("midrst_data", cpu_if.data, 0);
    check("midrst_overflow", cpu_if.overflow, 0);
    check("midrst_state", dbg_state, 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    base = err_pulses;
    send_frame(8'h29, 1'b0, 1'b1);
    check("post_rst_data", cpu_if.data, 8'h29);
    check("post_rst_err", err_pulses - base, 0);
    pop();
    check("post_rst_drained", cpu_if.valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
